// File: rtl/operand_fetch_ctrl_pkg.sv
// Shared types and constants for the operand fetch controller.
// Holds the AXI request/response structs, the tile configuration types,
// the fetch FSM encoding and the beats-per-matrix helper.
package operand_fetch_ctrl_pkg;

  localparam int DATA_W      = 256;
  localparam int BEAT_BYTES  = DATA_W / 8;
  localparam int TIMEOUT_CYC = 1024;

  // AXI size encoding: log2 of bytes per beat (32 bytes -> 5).
  localparam logic [2:0] ARSIZE_256 = 3'($clog2(BEAT_BYTES));

  // One-hot buffer select driven on the AXI request.
  localparam logic [2:0] SEL_C = 3'b001;
  localparam logic [2:0] SEL_A = 3'b100;
  localparam logic [2:0] SEL_B = 3'b010;

  typedef enum logic [1:0] {
    MAT_A = 2'd0,
    MAT_B = 2'd1,
    MAT_C = 2'd2
  } mat_t;

  typedef enum logic [1:0] {
    DT_FP32 = 2'd0,
    DT_FP16 = 2'd1,
    DT_INT8 = 2'd2,
    DT_INT4 = 2'd3
  } data_type_t;

  // compute_shape: 0 = M32K16N8, 1 = M16K16N16, 2 = M8K16N32, 3 = illegal.
  typedef struct packed {
    logic [1:0] compute_shape;
    data_type_t data_type;
  } compute_type_t;

  typedef struct packed {
    logic [31:0] A_BASE;
    logic [31:0] B_BASE;
    logic [31:0] C_BASE;
  } baseaddr_t;

  typedef struct packed {
    logic        request_valid;
    logic [31:0] BASE;
    logic [2:0]  sel;
    logic        issend;
    logic [2:0]  burst_size;
    logic [5:0]  burst_num;
  } AXI_out_t;

  typedef struct packed {
    logic              arready;
    logic              rvalid;
    logic              finish;
    logic [DATA_W-1:0] data;
  } AXI_in_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ_C = 3'd1,
    ST_DAT_C = 3'd2,
    ST_REQ_A = 3'd3,
    ST_DAT_A = 3'd4,
    ST_REQ_B = 3'd5,
    ST_DAT_B = 3'd6
  } fetch_state_t;

  // Beats needed to move one matrix: elements * element width / beat width.
  // A is M x 16, B is 16 x N, C is always 256 x 32-bit accumulators.
  function automatic logic [6:0] beats_f(input mat_t mat, input compute_type_t cfg);
    int dim;
    int width;
    int beats;
    case (cfg.data_type)
      DT_FP32: width = 32;
      DT_FP16: width = 16;
      DT_INT8: width = 8;
      default: width = 4;
    endcase
    case (cfg.compute_shape)
      2'd0:    dim = (mat == MAT_A) ? 32 : 8;
      2'd1:    dim = 16;
      2'd2:    dim = (mat == MAT_A) ? 8 : 32;
      default: dim = 0;
    endcase
    if (mat == MAT_C) beats = (256 * 32) / DATA_W;
    else              beats = (dim * 16 * width) / DATA_W;
    return 7'(beats);
  endfunction

endpackage

// File: rtl/operand_fetch_ctrl_fetch_size_lut.sv
// Combinational burst sizing for the matrix currently being fetched.
// Produces the beat count and the AXI burst_num (beats - 1).
module fetch_size_lut
  import operand_fetch_ctrl_pkg::*;
(
  input  mat_t          mat_i,
  input  compute_type_t cfg_i,
  output logic [6:0]    beats_o,
  output logic [5:0]    burst_num_o
);

  // Beat count and burst length from the latched tile configuration.
  always_comb begin
    beats_o     = beats_f(mat_i, cfg_i);
    burst_num_o = 6'(beats_o - 7'd1);
  end

endmodule

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch controller: issues AXI read bursts for C, then A, then B,
// and streams each returned beat into the selected operand buffer.
// Optional stall watchdog enabled by defining OPERAND_FETCH_TIMEOUT_EN.
module operand_fetch_ctrl
  import operand_fetch_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  compute_type_t     cfg_i,
  input  baseaddr_t         base_i,
  output AXI_out_t          axi_out_o,
  input  AXI_in_t           axi_in_i,
  output logic              buf_we_o,
  output mat_t              buf_sel_o,
  output logic [5:0]        buf_addr_o,
  output logic [DATA_W-1:0] buf_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  fetch_state_t      state_q, state_d;
  compute_type_t     cfg_q, cfg_d;
  baseaddr_t         base_q, base_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              buf_we_q, buf_we_d;
  mat_t              buf_sel_q, buf_sel_d;
  logic [5:0]        buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_wdata_q, buf_wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef OPERAND_FETCH_TIMEOUT_EN
  logic [15:0]       stall_q, stall_d;
`endif

  mat_t       cur_mat;
  logic       is_req;
  logic       is_dat;
  logic [6:0] beats;
  logic [5:0] burst_num;
  logic       last_beat;

  fetch_size_lut u_size_lut (
    .mat_i       (cur_mat),
    .cfg_i       (cfg_q),
    .beats_o     (beats),
    .burst_num_o (burst_num)
  );

  // Decode which matrix and which phase the FSM is in.
  always_comb begin
    cur_mat = MAT_C;
    is_req  = 1'b0;
    is_dat  = 1'b0;
    case (state_q)
      ST_REQ_C: begin cur_mat = MAT_C; is_req = 1'b1; end
      ST_DAT_C: begin cur_mat = MAT_C; is_dat = 1'b1; end
      ST_REQ_A: begin cur_mat = MAT_A; is_req = 1'b1; end
      ST_DAT_A: begin cur_mat = MAT_A; is_dat = 1'b1; end
      ST_REQ_B: begin cur_mat = MAT_B; is_req = 1'b1; end
      ST_DAT_B: begin cur_mat = MAT_B; is_dat = 1'b1; end
      default:  ;
    endcase
  end

  assign last_beat = ({1'b0, cnt_q} == (beats - 7'd1));

  // Next-state, beat counter and buffer-write generation.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cfg_d       = cfg_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    buf_we_d    = 1'b0;
    buf_sel_d   = buf_sel_q;
    buf_addr_d  = buf_addr_q;
    buf_wdata_d = buf_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
`ifdef OPERAND_FETCH_TIMEOUT_EN
    stall_d     = stall_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (cfg_i.compute_shape == 2'b11) begin
            err_d = 1'b1;
          end else begin
            cfg_d   = cfg_i;
            base_d  = base_i;
            cnt_d   = '0;
            state_d = ST_REQ_C;
          end
        end
      end

      ST_REQ_C, ST_REQ_A, ST_REQ_B: begin
        if (axi_in_i.arready) begin
          cnt_d = '0;
          case (state_q)
            ST_REQ_C: state_d = ST_DAT_C;
            ST_REQ_A: state_d = ST_DAT_A;
            default:  state_d = ST_DAT_B;
          endcase
        end
      end

      ST_DAT_C, ST_DAT_A, ST_DAT_B: begin
        if (axi_in_i.rvalid) begin
          buf_we_d    = 1'b1;
          buf_sel_d   = cur_mat;
          buf_addr_d  = cnt_q;
          buf_wdata_d = axi_in_i.data;
          cnt_d       = cnt_q + 6'd1;
          if (axi_in_i.finish != last_beat) begin
            // finish early, or the last beat without finish: abort the tile.
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else if (last_beat) begin
            cnt_d = '0;
            case (state_q)
              ST_DAT_C: state_d = ST_REQ_A;
              ST_DAT_A: state_d = ST_REQ_B;
              default: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
              end
            endcase
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

`ifdef OPERAND_FETCH_TIMEOUT_EN
    // Watchdog: any handshake or beat is progress; otherwise count stalled cycles.
    if (state_q == ST_IDLE) begin
      stall_d = '0;
    end else if ((is_req && axi_in_i.arready) || (is_dat && axi_in_i.rvalid)) begin
      stall_d = '0;
    end else if (stall_q == 16'(TIMEOUT_CYC)) begin
      stall_d = '0;
      err_d   = 1'b1;
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else begin
      stall_d = stall_q + 16'd1;
    end
`endif
  end

  // AXI read request: held stable for the whole REQ state until arready.
  always_comb begin
    axi_out_o = '0;
    if (is_req) begin
      axi_out_o.request_valid = 1'b1;
      axi_out_o.issend        = 1'b0;
      axi_out_o.burst_size    = ARSIZE_256;
      axi_out_o.burst_num     = burst_num;
      case (cur_mat)
        MAT_A: begin axi_out_o.BASE = base_q.A_BASE; axi_out_o.sel = SEL_A; end
        MAT_B: begin axi_out_o.BASE = base_q.B_BASE; axi_out_o.sel = SEL_B; end
        default: begin axi_out_o.BASE = base_q.C_BASE; axi_out_o.sel = SEL_C; end
      endcase
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign buf_we_o    = buf_we_q;
  assign buf_sel_o   = buf_sel_q;
  assign buf_addr_o  = buf_addr_q;
  assign buf_wdata_o = buf_wdata_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

  // State and output registers; reset drops any outstanding request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      base_q      <= '0;
      cnt_q       <= '0;
      buf_we_q    <= 1'b0;
      buf_sel_q   <= MAT_A;
      buf_addr_q  <= '0;
      buf_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef OPERAND_FETCH_TIMEOUT_EN
      stall_q     <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cfg_q       <= cfg_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      buf_we_q    <= buf_we_d;
      buf_sel_q   <= buf_sel_d;
      buf_addr_q  <= buf_addr_d;
      buf_wdata_q <= buf_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef OPERAND_FETCH_TIMEOUT_EN
      stall_q     <= stall_d;
`endif
    end
  end

endmodule
